// File: rtl/common_def.sv
// Shared definitions for the pipeline hazard control slice.
// Holds the hazard FSM state encoding and architectural constants.
package common_def;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2
  } hz_state_t;

  localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;
  localparam logic [4:0]  REG_X0        = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID and EX stages.
// Kept standalone so a forwarding unit can share the same compare.
module load_use_detect
  import common_def::*;
(
  input  logic       ex_memRead,
  input  logic       ex_regWrite,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       lu
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1 = id_use_rs1 && (ex_rd == id_rs1);
  assign hit_rs2 = id_use_rs2 && (ex_rd == id_rs2);

  assign lu = ex_memRead && ex_regWrite &&
              (ex_rd != REG_X0) &&
              (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, redirect, MEM wait, ECALL.
// Optional saturating perf counters when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import common_def::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_memRead,
  input  logic              ex_regWrite,
  input  logic              ex_redirect,
  input  logic              ex_ecall,
  input  logic              mem_busy,
  input  logic              resume,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_hold,
  output logic              idex_flush,
  output logic              exmem_hold,
  output logic              halted,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0] perf_lu_stalls,
  output logic [PERF_W-1:0] perf_mem_stalls,
  output logic [PERF_W-1:0] perf_flushes,
`endif
  output logic [2:0]        state_o
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || PERF_W < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: illegal DRAIN_CYCLES or PERF_W");
  end

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  hz_state_t  state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       lu;

  load_use_detect u_lu (
    .ex_memRead  (ex_memRead),
    .ex_regWrite (ex_regWrite),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .lu          (lu)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (mem_busy) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end else if (ex_ecall) begin
            pc_hold     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            drain_cnt_d = DRAIN_LOAD;
            state_d     = DRAIN;
          end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end
        end
        DRAIN: begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (mem_busy) begin
            exmem_hold = 1'b1;
          end else if (drain_cnt_q == 4'd0) begin
            state_d = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
        HALTED: begin
          halted     = 1'b1;
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (resume) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign state_o = rst ? RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic              ev_lu, ev_mem, ev_flush;
  logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [PERF_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [PERF_W-1:0] fl_cnt_q, fl_cnt_d;

  // Events mirror the priority chain so each stall cycle is counted once.
  assign ev_mem   = mem_busy && (state_q != HALTED);
  assign ev_flush = (state_q == RUN) && !mem_busy &&
                    !ex_ecall && ex_redirect;
  assign ev_lu    = (state_q == RUN) && !mem_busy &&
                    !ex_ecall && !ex_redirect && lu;

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    if (ev_lu && (lu_cnt_q != '1))     lu_cnt_d  = lu_cnt_q + 1'b1;
    if (ev_mem && (mem_cnt_q != '1))   mem_cnt_d = mem_cnt_q + 1'b1;
    if (ev_flush && (fl_cnt_q != '1))  fl_cnt_d  = fl_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign perf_lu_stalls  = lu_cnt_q;
  assign perf_mem_stalls = mem_cnt_q;
  assign perf_flushes    = fl_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipe (IF/ID/EX/MEM/WB). It detects load-use hazards, EX-stage control redirects, multi-cycle data-memory waits and ECALL retirement. It drives the hold/flush controls of the PC, IFID, IDEX and EXMEM pipeline registers, plus a halt indication.
It is a small FSM with a drain counter, instantiated once in the pipe top level.

Parameters:
DRAIN_CYCLES, 3, cycles after ECALL is seen in EX before HALTED is entered (lets EX/MEM/WB retire); legal 1..15
PERF_W, 32, width of optional performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 field of instruction in ID
id_rs2  in  5  rs2 field of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX (IDEX output)
ex_memRead  in  1  EX instruction is a load
ex_regWrite  in  1  EX instruction writes rd
ex_redirect  in  1  EX resolved taken branch/jump (PC redirect)
ex_ecall  in  1  ECALL flag at IDEX output
mem_busy  in  1  data memory has not completed MEM-stage access this cycle
resume  in  1  single-cycle pulse releasing HALTED
pc_hold  out  1  PC register keeps value
ifid_hold  out  1  IFID keeps contents
ifid_flush  out  1  IFID loads NOP
idex_hold  out  1  IDEX keeps contents
idex_flush  out  1  IDEX loads NOP bubble
exmem_hold  out  1  EXMEM keeps contents
halted  out  1  core halted after ECALL
state_o  out  3  current FSM state (debug)

Behaviour:
- Single clock domain; reset synchronous active-high: state<=RUN, drain_cnt<=0, perf counters<=0. While rst=1 all control outputs are forced to 0 (halted=0, state_o=RUN).
- Outputs are combinational from state and the current-cycle inputs; they take effect at the next clk edge in the target registers. No added latency.
- States: RUN, DRAIN, HALTED (enum in package; state_o = enum encoding).
- Load-use condition LU = ex_memRead & ex_regWrite & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- RUN priority, highest first:
  1. mem_busy: pc_hold=ifid_hold=idex_hold=exmem_hold=1, no flushes; state unchanged. EX is frozen, so any redirect/LU re-evaluates next cycle.
  2. ex_ecall: pc_hold=1, ifid_flush=idex_flush=1; drain_cnt<=DRAIN_CYCLES-1; state->DRAIN.
  3. ex_redirect: ifid_flush=idex_flush=1, no holds. Redirect beats LU because ID is wrong-path.
  4. LU: pc_hold=ifid_hold=1, idex_flush=1 for exactly one cycle. The next cycle the load has left EX, so LU clears.
  5. Otherwise all outputs 0.
- DRAIN: pc_hold=1, ifid_flush=idex_flush=1 every cycle.
  - If mem_busy=1: additionally exmem_hold=1 and drain_cnt pauses.
  - Else if drain_cnt==0: state->HALTED. Else drain_cnt decrements.
  - ex_redirect and LU are ignored.
- HALTED: halted=1, pc_hold=1, ifid_flush=idex_flush=1. resume=1 -> RUN next cycle (halted drops the same edge). resume in RUN/DRAIN is ignored.
- Simultaneous mem_busy and ex_ecall in RUN: the stall wins; ECALL is taken once mem_busy drops.
- hold and flush are never both asserted on the same register.
- Reset mid-DRAIN or mid-HALTED returns to RUN next edge, with the counter cleared.

Optional Feature:
HAZARD_PERF_CNT_EN: when defined, adds outputs perf_lu_stalls, perf_mem_stalls and perf_flushes [PERF_W-1:0].
- They count cycles with LU stall (RUN, rule 4), cycles with mem_busy stall (any state), and cycles with ex_redirect flush (RUN, rule 3).
- Counters saturate at all-ones and clear on rst.
When undefined, these ports and registers are absent and the behaviour is otherwise identical.

Decomposition:
- common_def package: hz_state_t enum (RUN=0, DRAIN=1, HALTED=2), NOP_INSTR_HEX (already present), REG_X0=5'd0.
- One natural sub-module: load_use_detect (pure combinational LU compare), reused by a future forwarding unit.
- FSM and counter stay in pipe_hazard_ctrl.

Test Plan:
1. ex_memRead=1, ex_regWrite=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_hold=ifid_hold=idex_flush=1; next cycle (ex_memRead=0) all 0.
2. Same as 1 but ex_rd=0 -> no stall; ex_rd=5 with id_use_rs1=0, id_rs2=5, id_use_rs2=1 -> stall.
3. ex_redirect=1 together with the LU condition -> ifid_flush=idex_flush=1, pc_hold=0, ifid_hold=0.
4. mem_busy=1 for 4 cycles with ex_redirect=1 -> 4 cycles of all holds, no flush; on cycle 5 (mem_busy=0) flushes assert.
5. ex_ecall=1 with DRAIN_CYCLES=3 -> state DRAIN for 3 cycles; mem_busy=1 in the 2nd extends it to 4; then halted=1; resume pulse -> state RUN next cycle, halted=0.
6. Assert rst in HALTED -> next cycle state_o=RUN, all outputs 0; with HAZARD_PERF_CNT_EN, 3 LU stalls then reset -> perf_lu_stalls 3 then 0.
